// File: rtl/pipeline_stall_ctrl_if.sv
// Stall controller bus: hazard/memory requests in,
// pipeline enables, flushes, status and counters out.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             data_hazard;
  logic             control_hazard;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_write;
  logic             mem_wb_write;
  logic             mem_wait;
  logic             fault;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt;

  modport master (
    output data_hazard, control_hazard,
    output mem_req, mem_ready,
    input  pc_write, if_id_write,
    input  if_id_flush, id_ex_flush,
    input  ex_mem_write, mem_wb_write,
    input  mem_wait, fault,
    input  stall_cnt, flush_cnt, wait_cnt
  );

  modport slave (
    input  data_hazard, control_hazard,
    input  mem_req, mem_ready,
    output pc_write, if_id_write,
    output if_id_flush, id_ex_flush,
    output ex_mem_write, mem_wb_write,
    output mem_wait, fault,
    output stall_cnt, flush_cnt, wait_cnt
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// 5-stage pipeline stall/flush controller with
// memory-wait freeze, timeout fault and perf counters.
module pipeline_stall_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pipeline_stall_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             freeze;
  logic             do_stall;
  logic             do_flush;

  // State and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      tmo_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      wait_q  <= wait_d;
    end
  end

  // Freeze and hazard priority decode
  always_comb begin
    freeze = 1'b1;
    unique case (state_q)
      RUN:     freeze = bus.mem_req && !bus.mem_ready;
      WAIT:    freeze = !bus.mem_ready;
      FAULT:   freeze = 1'b1;
      default: freeze = 1'b1;
    endcase
    do_stall = !freeze && bus.data_hazard;
    do_flush = !freeze && !bus.data_hazard
             && bus.control_hazard;
  end

  // Next state, timeout counter and perf counters
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          state_d = WAIT;
          tmo_d   = ONE;
        end
      end
      WAIT: begin
        if (bus.mem_ready) begin
          state_d = RUN;
        end else if (tmo_q == TMO) begin
          state_d = FAULT;
        end else begin
          tmo_d = tmo_q + ONE;
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
    stall_d = stall_q;
    flush_d = flush_q;
    wait_d  = wait_q;
    if (do_stall && stall_q != MAX) begin
      stall_d = stall_q + ONE;
    end
    if (do_flush && flush_q != MAX) begin
      flush_d = flush_q + ONE;
    end
    if (freeze && state_q != FAULT && wait_q != MAX) begin
      wait_d = wait_q + ONE;
    end
  end

  // Pipeline enables/flushes and status outputs
  always_comb begin
    bus.pc_write     = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_write = 1'b1;
    bus.mem_wb_write = 1'b1;
    priority case (1'b1)
      freeze: begin
        bus.pc_write     = 1'b0;
        bus.if_id_write  = 1'b0;
        bus.ex_mem_write = 1'b0;
        bus.mem_wb_write = 1'b0;
      end
      do_stall: begin
        bus.pc_write    = 1'b0;
        bus.if_id_write = 1'b0;
        bus.id_ex_flush = 1'b1;
      end
      do_flush: begin
        bus.if_id_flush = 1'b1;
      end
      default: ;
    endcase
    bus.mem_wait  = (state_q == WAIT);
    bus.fault     = (state_q == FAULT);
    bus.stall_cnt = stall_q;
    bus.flush_cnt = flush_q;
    bus.wait_cnt  = wait_q;
  end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Testbench for pipeline_stall_ctrl: directed
// scenarios plus randomized run against a model.
module tb_pipeline_stall_ctrl;
  localparam int CNT_W = 3;
  localparam int TMO   = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus();

  pipeline_stall_ctrl #(
    .CNT_W(CNT_W),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ctrl vector: pc, ifw, iff, idf, exw, mww
  logic [5:0] obs;
  assign obs = {bus.pc_write, bus.if_id_write,
                bus.if_id_flush, bus.id_ex_flush,
                bus.ex_mem_write, bus.mem_wb_write};

  bit m_wait;
  bit m_fault;
  int m_wlen;
  int m_stall;
  int m_flush;
  int m_waitc;

  function automatic bit m_freeze();
    if (m_fault) return 1'b1;
    if (m_wait) return !bus.mem_ready;
    return bus.mem_req && !bus.mem_ready;
  endfunction

  function automatic logic [5:0] m_ctrl();
    if (m_freeze()) return 6'b000000;
    if (bus.data_hazard) return 6'b000111;
    if (bus.control_hazard) return 6'b111011;
    return 6'b110011;
  endfunction

  task automatic model_reset();
    m_wait  = 1'b0;
    m_fault = 1'b0;
    m_wlen  = 0;
    m_stall = 0;
    m_flush = 0;
    m_waitc = 0;
  endtask

  task automatic model_step();
    bit fz;
    fz = m_freeze();
    if (!fz && bus.data_hazard) begin
      if (m_stall < SAT) m_stall++;
    end else if (!fz && bus.control_hazard) begin
      if (m_flush < SAT) m_flush++;
    end
    if (fz && !m_fault && m_waitc < SAT) m_waitc++;
    if (!m_fault) begin
      if (m_wait) begin
        if (bus.mem_ready) m_wait = 1'b0;
        else if (m_wlen >= TMO) begin
          m_wait  = 1'b0;
          m_fault = 1'b1;
        end else m_wlen++;
      end else if (bus.mem_req && !bus.mem_ready) begin
        m_wait = 1'b1;
        m_wlen = 1;
      end
    end
  endtask

  task automatic set_in(input bit dh, input bit ch,
                        input bit mr, input bit rdy);
    bus.data_hazard    = dh;
    bus.control_hazard = ch;
    bus.mem_req        = mr;
    bus.mem_ready      = rdy;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.data_hazard    = 1'b0;
    bus.control_hazard = 1'b0;
    bus.mem_req        = 1'b0;
    bus.mem_ready      = 1'b0;
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 0);
      checks++;
      if (obs !== 6'b110011) begin
        errors++;
        $display("FAIL reset_ctrl cyc%0d got %b want 110011", i, obs);
      end
      tick();
    end
    checks++;
    if ({bus.stall_cnt, bus.flush_cnt, bus.wait_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d/%0d want 0/0/0",
               bus.stall_cnt, bus.flush_cnt, bus.wait_cnt);
    end
    checks++;
    if ({bus.mem_wait, bus.fault} !== 2'b00) begin
      errors++;
      $display("FAIL reset_status got %b%b want 00",
               bus.mem_wait, bus.fault);
    end
  endtask

  task automatic test_data_hazard();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(1, i == 1, 0, 0);
      checks++;
      if (obs !== 6'b000111) begin
        errors++;
        $display("FAIL dh_ctrl cyc%0d got %b want 000111", i, obs);
      end
      tick();
    end
    set_in(0, 0, 0, 0);
    checks++;
    if (bus.stall_cnt !== 3'd2 || bus.flush_cnt !== 3'd0) begin
      errors++;
      $display("FAIL dh_cnt got %0d/%0d want 2/0",
               bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_control_hazard();
    do_reset();
    set_in(0, 1, 0, 0);
    checks++;
    if (obs !== 6'b111011) begin
      errors++;
      $display("FAIL ch_ctrl got %b want 111011", obs);
    end
    tick();
    set_in(0, 0, 0, 0);
    checks++;
    if (bus.flush_cnt !== 3'd1) begin
      errors++;
      $display("FAIL ch_cnt got %0d want 1", bus.flush_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 1, 0);
      checks++;
      if (obs !== 6'b000000) begin
        errors++;
        $display("FAIL mw_freeze cyc%0d got %b want 000000", i, obs);
      end
      checks++;
      if (bus.mem_wait !== (i != 0)) begin
        errors++;
        $display("FAIL mw_status cyc%0d got %b want %b",
                 i, bus.mem_wait, i != 0);
      end
      tick();
    end
    set_in(1, 0, 1, 1);
    checks++;
    if (obs !== 6'b000111) begin
      errors++;
      $display("FAIL mw_release got %b want 000111", obs);
    end
    tick();
    set_in(0, 0, 0, 0);
    checks++;
    if (bus.wait_cnt !== 3'd3 || bus.stall_cnt !== 3'd1) begin
      errors++;
      $display("FAIL mw_cnt got %0d/%0d want 3/1",
               bus.wait_cnt, bus.stall_cnt);
    end
    checks++;
    if (bus.mem_wait !== 1'b0) begin
      errors++;
      $display("FAIL mw_exit got %b want 0", bus.mem_wait);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < TMO + 1; i++) begin
      set_in(0, 1, 1, 0);
      checks++;
      if (bus.fault !== 1'b0 || obs !== 6'b000000) begin
        errors++;
        $display("FAIL to_pre cyc%0d got %b/%b want 0/000000",
                 i, bus.fault, obs);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 1, 1);
      checks++;
      if (bus.fault !== 1'b1 || obs !== 6'b000000) begin
        errors++;
        $display("FAIL to_fault cyc%0d got %b/%b want 1/000000",
                 i, bus.fault, obs);
      end
      checks++;
      if (bus.wait_cnt !== 3'd5 || bus.mem_wait !== 1'b0) begin
        errors++;
        $display("FAIL to_cnt cyc%0d got %0d/%b want 5/0",
                 i, bus.wait_cnt, bus.mem_wait);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(1, 0, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0);
    checks++;
    if (bus.stall_cnt !== 3'd7) begin
      errors++;
      $display("FAIL sat_cnt got %0d want 7", bus.stall_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_in(1, 0, 0, 0);
    tick();
    set_in(0, 0, 1, 0);
    tick();
    tick();
    checks++;
    if (bus.mem_wait !== 1'b1 || bus.stall_cnt !== 3'd1) begin
      errors++;
      $display("FAIL ar_pre got %b/%0d want 1/1",
               bus.mem_wait, bus.stall_cnt);
    end
    bus.mem_req = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bus.mem_wait, bus.fault} !== 2'b00) begin
      errors++;
      $display("FAIL ar_status got %b%b want 00",
               bus.mem_wait, bus.fault);
    end
    checks++;
    if ({bus.stall_cnt, bus.flush_cnt, bus.wait_cnt} !== '0) begin
      errors++;
      $display("FAIL ar_cnt got %0d/%0d/%0d want 0/0/0",
               bus.stall_cnt, bus.flush_cnt, bus.wait_cnt);
    end
    checks++;
    if (obs !== 6'b110011) begin
      errors++;
      $display("FAIL ar_ctrl got %b want 110011", obs);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [5:0] exp;
    for (int s = 0; s < 8; s++) begin
      do_reset();
      for (int i = 0; i < 40; i++) begin
        set_in($urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) < ((s % 2) ? 1 : 3));
        exp = m_ctrl();
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL rnd_ctrl s%0d c%0d got %b want %b",
                   s, i, obs, exp);
        end
        checks++;
        if (bus.mem_wait !== m_wait || bus.fault !== m_fault) begin
          errors++;
          $display("FAIL rnd_status s%0d c%0d got %b%b want %b%b",
                   s, i, bus.mem_wait, bus.fault, m_wait, m_fault);
        end
        checks++;
        if (bus.stall_cnt !== CNT_W'(m_stall)
            || bus.flush_cnt !== CNT_W'(m_flush)
            || bus.wait_cnt !== CNT_W'(m_waitc)) begin
          errors++;
          $display("FAIL rnd_cnt s%0d c%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                   s, i, bus.stall_cnt, bus.flush_cnt, bus.wait_cnt,
                   m_stall, m_flush, m_waitc);
        end
        tick();
      end
    end
  endtask

  initial begin
    bus.data_hazard    = 1'b0;
    bus.control_hazard = 1'b0;
    bus.mem_req        = 1'b0;
    bus.mem_ready      = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_data_hazard();
    test_control_hazard();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumes the hazard unit's `data_hazard` and `control_hazard` requests, plus the data-memory ready handshake.
- Produces every pipeline-register enable and flush, and the PC write enable, for the 5-stage MIPS core.
- Adds a memory-wait freeze with a timeout watchdog, a sticky fault state and saturating stall/flush performance counters.
- Sits between the hazard unit, the data-memory port and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- `CNT_W`, 16, width of each performance counter.
- `MEM_TIMEOUT`, 255, max consecutive memory-wait cycles before fault; legal range 1..2^`CNT_W`-1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_hazard`  in  1  load-use / branch-operand stall request from the hazard unit.
- `control_hazard`  in  1  taken jump/branch; the IF/ID instruction must be squashed.
- `mem_req`  in  1  EX/MEM stage holds a load or store.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_write`  out  1  PC register enable.
- `if_id_write`  out  1  IF/ID register enable.
- `if_id_flush`  out  1  IF/ID clear (insert nop).
- `id_ex_flush`  out  1  ID/EX clear (bubble).
- `ex_mem_write`  out  1  EX/MEM register enable.
- `mem_wb_write`  out  1  MEM/WB register enable.
- `mem_wait`  out  1  registered: controller in `WAIT` state.
- `fault`  out  1  registered, sticky memory-timeout fault.
- `stall_cnt`  out  `CNT_W`  data-hazard stall cycles, saturating.
- `flush_cnt`  out  `CNT_W`  control-hazard flush cycles, saturating.
- `wait_cnt`  out  `CNT_W`  memory freeze cycles, saturating.

Behaviour:
- States:
  - `RUN` (reset).
  - `WAIT` (memory access outstanding).
  - `FAULT` (terminal until reset).
- Define `freeze = (state==WAIT && !mem_ready) || (state==RUN && mem_req && !mem_ready) || state==FAULT`.
- Control outputs are combinational from inputs and state; zero-latency.
- Priority 1, `freeze`:
  - `pc_write`, `if_id_write`, `ex_mem_write`, `mem_wb_write` all 0.
  - All flushes 0.
  - Hazard inputs are ignored and not counted.
- Priority 2, `data_hazard` (no freeze):
  - `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1.
  - `ex_mem_write`=`mem_wb_write`=1.
  - `if_id_flush`=0, even if `control_hazard` is also high.
- Priority 3, `control_hazard` (no freeze, no `data_hazard`):
  - `pc_write`=1, `if_id_write`=1, `if_id_flush`=1, `id_ex_flush`=0.
  - Downstream enables are 1.
- Otherwise: all enables 1, all flushes 0.
- Transitions:
  - `RUN`→`WAIT` when `mem_req && !mem_ready`.
  - `WAIT`→`RUN` on `mem_ready`; that cycle the pipeline advances normally, with hazard priorities applied.
  - `WAIT`→`FAULT` when the internal wait counter reaches `MEM_TIMEOUT` with `mem_ready` still low. The counter reloads to 1 on `RUN`→`WAIT` and increments each `WAIT` cycle.
  - `mem_ready` on the same edge as the timeout wins: go to `RUN`.
  - `FAULT` is left only by reset. `fault`=1 from the cycle after entry.
- `mem_req` with `mem_ready` already high in `RUN`: no freeze, no state change.
- `mem_ready` while `mem_req`=0 in `RUN`: ignored.
- Counters:
  - `stall_cnt` increments on cycles where priority 2 applies.
  - `flush_cnt` increments on cycles where priority 3 applies.
  - `wait_cnt` increments on every `freeze` cycle except in `FAULT`.
  - Each holds at 2^`CNT_W`-1.
- Reset (async assert, any state including mid-`WAIT`):
  - state=`RUN`; `fault`=0; `mem_wait`=0; all counters and the wait counter 0.
  - Control outputs then follow the `RUN` rules immediately, so with idle inputs all enables are 1 and flushes 0.

Test Plan:
- Reset release, all inputs 0 for 5 cycles → enables 1, flushes 0, all counters 0, `mem_wait`=0, `fault`=0.
- `data_hazard`=1 for 2 cycles, `control_hazard`=1 on the second → `pc_write`=`if_id_write`=0, `id_ex_flush`=1 both cycles, `if_id_flush`=0, `stall_cnt`=2, `flush_cnt`=0.
- `control_hazard`=1 for 1 cycle → `if_id_flush`=1, `pc_write`=1, `flush_cnt`=1.
- `mem_req`=1 with `mem_ready` low for 3 cycles then high, `data_hazard`=1 throughout →
  - 3 freeze cycles with all enables 0; `mem_wait`=1 from cycle 2.
  - 4th cycle applies `data_hazard` rules.
  - `wait_cnt`=3, `stall_cnt`=1.
- `MEM_TIMEOUT`=4, `mem_req`=1, `mem_ready` never high → `fault`=1 after timeout, enables stay 0, `wait_cnt` frozen; `mem_ready`=1 later does not exit.
- `CNT_W`=3, `data_hazard` held 10 cycles → `stall_cnt`=7; `reset_n` pulse mid-`WAIT` → all state and counters 0 asynchronously.
